// File: rtl/fetch_queue.sv
// Instruction fetch FIFO between the PC/instruction-memory stage and decode.
// Optional zero-latency bypass when empty: define FETCH_QUEUE_BYPASS_EN.
`ifndef IM_ADDR_BIT
`define IM_ADDR_BIT 16
`endif

module fetch_queue #(
  parameter int ADDR_W = `IM_ADDR_BIT,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [ADDR_W-1:0]        in_pc,
  input  logic [DATA_W-1:0]        in_instr,
  output logic                     fetch_en,
  input  logic                     flush,
  output logic                     out_valid,
  output logic [ADDR_W-1:0]        out_pc,
  output logic [ADDR_W-1:0]        out_pc_4,
  output logic [DATA_W-1:0]        out_instr,
  input  logic                     out_pop,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err_underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              err_underflow_q, err_underflow_d;

  logic [ADDR_W-1:0] pc_mem    [DEPTH];
  logic [DATA_W-1:0] instr_mem [DEPTH];

  logic full, empty;
  logic push_ok, pop_ok, bypass_take;

  always_comb begin
    full        = (count_q == CNT_W'(DEPTH));
    empty       = (count_q == '0);
    fetch_en    = !full;
    out_valid   = !empty;
    out_pc      = pc_mem[rd_ptr_q];
    out_instr   = instr_mem[rd_ptr_q];
    bypass_take = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
    // An entry arriving into an empty queue is visible at once; if decode
    // takes it in the same cycle it never needs to be stored.
    if (empty && in_valid && !flush) begin
      out_valid   = 1'b1;
      out_pc      = in_pc;
      out_instr   = in_instr;
      bypass_take = out_pop;
    end
`endif
    out_pc_4 = out_pc + ADDR_W'(1);
  end

  always_comb begin
    push_ok         = in_valid && !full && !flush && !bypass_take;
    pop_ok          = out_pop && out_valid && !flush && !bypass_take;
    rd_ptr_d        = rd_ptr_q;
    wr_ptr_d        = wr_ptr_q;
    count_d         = count_q;
    err_underflow_d = err_underflow_q || (out_pop && !out_valid);

    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // A redirect outranks everything except the sticky error flag.
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q        <= '0;
      wr_ptr_q        <= '0;
      count_q         <= '0;
      err_underflow_q <= 1'b0;
    end else begin
      rd_ptr_q        <= rd_ptr_d;
      wr_ptr_q        <= wr_ptr_d;
      count_q         <= count_d;
      err_underflow_q <= err_underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      pc_mem[wr_ptr_q]    <= in_pc;
      instr_mem[wr_ptr_q] <= in_instr;
    end
  end

  assign count         = count_q;
  assign err_underflow = err_underflow_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue (DEPTH=4, ADDR_W=8); follows the bypass
// behaviour when FETCH_QUEUE_BYPASS_EN is defined.
module tb_fetch_queue;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } entry_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic [ADDR_W-1:0] in_pc = '0;
  logic [DATA_W-1:0] in_instr = '0;
  logic              fetch_en;
  logic              flush = 1'b0;
  logic              out_valid;
  logic [ADDR_W-1:0] out_pc;
  logic [ADDR_W-1:0] out_pc_4;
  logic [DATA_W-1:0] out_instr;
  logic              out_pop = 1'b0;
  logic [2:0]        count;
  logic              err_underflow;

  entry_t sbQ[$];
  bit     modelErr = 1'b0;
  int     testsRun = 0;
  int     testsFailed = 0;

  fetch_queue #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr),
    .fetch_en(fetch_en), .flush(flush),
    .out_valid(out_valid), .out_pc(out_pc), .out_pc_4(out_pc_4),
    .out_instr(out_instr), .out_pop(out_pop),
    .count(count), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [DATA_W-1:0] mkInstr(input logic [ADDR_W-1:0] pc);
    return 32'hC0DE_0000 | {24'h0, pc} | ({24'h0, ~pc} << 8);
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", tag, actual, expected);
    end
  endtask

  // Compares every visible output against the scoreboard state.
  task automatic checkState(input string tag);
    logic [ADDR_W-1:0] nextPc;
    checkOutput({tag, "_count"}, 64'(count), 64'(sbQ.size()));
    checkOutput({tag, "_valid"}, 64'(out_valid), 64'(sbQ.size() != 0));
    checkOutput({tag, "_fetch_en"}, 64'(fetch_en), 64'(sbQ.size() < DEPTH));
    checkOutput({tag, "_err"}, 64'(err_underflow), 64'(modelErr));
    if (sbQ.size() > 0) begin
      nextPc = sbQ[0].pc + 8'd1;
      checkOutput({tag, "_pc"}, 64'(out_pc), 64'(sbQ[0].pc));
      checkOutput({tag, "_pc_4"}, 64'(out_pc_4), 64'(nextPc));
      checkOutput({tag, "_instr"}, 64'(out_instr), 64'(sbQ[0].instr));
    end
  endtask

  task automatic applyStimulus(input string tag, input logic v,
                               input logic [ADDR_W-1:0] pc,
                               input logic pop, input logic fl);
    bit    accept;
    bit    bypassTake;
    entry_t e;
    @(negedge clk);
    e.pc = pc;
    e.instr = mkInstr(pc);
    in_valid = v;
    in_pc = pc;
    in_instr = e.instr;
    out_pop = pop;
    flush = fl;
    #1;
    bypassTake = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
    if (sbQ.size() == 0 && v && !fl) begin
      checkOutput({tag, "_byp_valid"}, 64'(out_valid), 64'd1);
      checkOutput({tag, "_byp_pc"}, 64'(out_pc), 64'(pc));
      checkOutput({tag, "_byp_instr"}, 64'(out_instr), 64'(e.instr));
      bypassTake = pop;
    end
`endif
    if (pop && !fl && sbQ.size() > 0) begin
      checkOutput({tag, "_pop_pc"}, 64'(out_pc), 64'(sbQ[0].pc));
      checkOutput({tag, "_pop_instr"}, 64'(out_instr), 64'(sbQ[0].instr));
    end
    @(posedge clk);
    #1;
    if (pop && sbQ.size() == 0 && !bypassTake) modelErr = 1'b1;
    if (fl) begin
      sbQ.delete();
    end else begin
      accept = v && (sbQ.size() < DEPTH) && !bypassTake;
      if (pop && sbQ.size() > 0) void'(sbQ.pop_front());
      if (accept) sbQ.push_back(e);
    end
    in_valid = 1'b0;
    out_pop = 1'b0;
    flush = 1'b0;
    #1;
    checkState(tag);
  endtask

  initial begin
    #12;
    checkState("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) applyStimulus("fill", 1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
    applyStimulus("fill_over", 1'b1, 8'h14, 1'b0, 1'b0);
    checkOutput("head_pc", 64'(out_pc), 64'h10);
    checkOutput("head_pc_4", 64'(out_pc_4), 64'h11);

    applyStimulus("full_pushpop", 1'b1, 8'h15, 1'b1, 1'b0);
    checkOutput("full_pushpop_head", 64'(out_pc), 64'h11);
    checkOutput("full_pushpop_count", 64'(count), 64'd3);

    applyStimulus("flush", 1'b1, 8'h16, 1'b1, 1'b1);
    checkOutput("flush_count", 64'(count), 64'd0);
    applyStimulus("post_flush", 1'b1, 8'h40, 1'b0, 1'b0);
    checkOutput("post_flush_head", 64'(out_pc), 64'h40);
    applyStimulus("pop40", 1'b0, 8'h00, 1'b1, 1'b0);

    for (int i = 0; i < 4; i++) applyStimulus("refill", 1'b1, 8'h30 + 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus("drain", 1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus("wrap_first", 1'b1, 8'h20, 1'b0, 1'b0);
    for (int i = 1; i < 6; i++) applyStimulus("wrap", 1'b1, 8'h20 + 8'(i), 1'b1, 1'b0);
    applyStimulus("wrap_last", 1'b0, 8'h00, 1'b1, 1'b0);

    applyStimulus("underflow", 1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("underflow_flag", 64'(err_underflow), 64'd1);
    applyStimulus("flush_keeps_err", 1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("err_sticky", 64'(err_underflow), 64'd1);

    applyStimulus("max_pc", 1'b1, 8'hFF, 1'b0, 1'b0);
    checkOutput("max_pc_4", 64'(out_pc_4), 64'h00);
    applyStimulus("max_pop", 1'b0, 8'h00, 1'b1, 1'b0);

    applyStimulus("pre_reset", 1'b1, 8'h50, 1'b0, 1'b0);
    applyStimulus("pre_reset", 1'b1, 8'h51, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b1;
    in_pc = 8'h52;
    rst_n = 1'b0;
    #1;
    sbQ.delete();
    modelErr = 1'b0;
    checkState("async_reset");
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus("after_reset", 1'b1, 8'h60, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Small instruction fetch FIFO sitting directly downstream of the synchronous PC / instruction-memory stage, upstream of decode.
- Captures {pc, instruction} pairs produced each fetch cycle and releases them to decode with a valid/pop handshake.
- Drives the PC stage's enable, so fetch stalls when the queue is full.
- Flushes all entries on a control-flow redirect (when the PC stage is loaded with a new target).

Parameters:
- ADDR_W, default `IM_ADDR_BIT: width of stored PC (word address).
- DATA_W, default 32: instruction width.
- DEPTH, default 4: number of entries; power of two, minimum 2.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  fetch stage presents a valid {in_pc, in_instr} this cycle.
- in_pc  input  ADDR_W  PC of fetched instruction.
- in_instr  input  DATA_W  fetched instruction word.
- fetch_en  output  1  enable to PC stage; equals !full.
- flush  input  1  redirect; discard all queued entries.
- out_valid  output  1  head entry available to decode.
- out_pc  output  ADDR_W  PC of head entry.
- out_pc_4  output  ADDR_W  out_pc + 1, truncated to ADDR_W (wraps).
- out_instr  output  DATA_W  head instruction.
- out_pop  input  1  decode consumes head this cycle.
- count  output  clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- err_underflow  output  1  sticky flag: out_pop seen while out_valid=0.

Behaviour:
- Reset (async, rst_n low):
  - rd_ptr=0, wr_ptr=0, count=0, err_underflow=0.
  - fetch_en=1, out_valid=0.
  - Storage array is not reset; out_pc/out_instr are don't-care while out_valid=0.
- Full/empty derivation:
  - full = (count==DEPTH); empty = (count==0).
  - fetch_en = !full, purely from registered count; no combinational path from out_pop to fetch_en.
- Push:
  - Accepted when in_valid && !full && !flush.
  - Writes entry[wr_ptr]; wr_ptr increments modulo DEPTH.
  - in_valid while full is ignored silently; the PC stage is already stalled.
- Pop:
  - Accepted when out_pop && out_valid && !flush.
  - rd_ptr increments modulo DEPTH.
- Simultaneous push and pop, neither full nor empty: both happen, count unchanged.
- Simultaneous push and pop when full: pop only. Push is rejected because fetch_en was 0 that cycle; count decrements.
- Simultaneous push and pop when empty: push only (the pop is an underflow, see below); count becomes 1.
- Latency (default build): a pushed entry appears at the output (out_valid=1) on the cycle after the push edge; no bypass.
- Output mux: out_* = entry[rd_ptr]; out_valid = !empty.
- Flush:
  - Synchronous, highest priority.
  - On the next edge: rd_ptr=wr_ptr=0, count=0.
  - A push or pop in the same cycle is discarded.
  - err_underflow is unaffected.
- Underflow:
  - out_pop && !out_valid sets err_underflow on the next edge; it stays set until reset.
  - Queue state is unchanged.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally; count alone distinguishes full from empty.
- Reset mid-operation: all entries are lost immediately; outputs take reset values asynchronously.

Optional Feature:
- Macro: FETCH_QUEUE_BYPASS_EN.
- Defined:
  - When empty and in_valid && !flush, out_valid=1 and out_pc/out_instr come combinationally from in_pc/in_instr.
  - If out_pop is also asserted that cycle, the entry is consumed without being written; count stays 0.
  - If not popped, it is written normally.
  - Zero-cycle fetch-to-decode latency when empty.
- Not defined: one-cycle minimum latency as described above; no combinational path from in_* to out_*.

Test Plan:
- Reset: hold rst_n=0 mid-traffic -> count=0, out_valid=0, fetch_en=1, err_underflow=0 immediately, without a clock edge.
- Fill (DEPTH=4, out_pop=0):
  - Push pc 0x10..0x13 on 4 cycles -> count=4 and fetch_en=0 after the 4th edge.
  - A 5th push with pc 0x14 is ignored.
  - Head reads out_pc=0x10, out_pc_4=0x11.
- Drain with wrap:
  - Pop 4, then push 0x20..0x25 while popping each cycle -> outputs in order 0x20..0x25, count steady at 1.
  - Pointers wrap past index 3 without loss.
- Full push/pop: with count=4, assert in_valid and out_pop together -> count=3, head advances to 0x11, the pushed value is not stored.
- Flush:
  - count=3, assert flush with in_valid=1 and out_pop=1 -> next cycle count=0, out_valid=0.
  - The following push of pc 0x40 appears as head one cycle later (two builds: zero cycles with FETCH_QUEUE_BYPASS_EN when empty).
- Underflow and edge wrap:
  - Pop while empty -> err_underflow=1 and stays 1 after a later flush.
  - Head pc at the maximum ADDR_W value -> out_pc_4=0.
